csa_sbox_seq: RTL
=================

Name: csa_sbox_seq

Overview:
- Sequential S-box evaluation engine for the CSA stream cipher.
- Each transaction evaluates all seven 5-in/2-out stream-cipher S-boxes (sbox1..sbox7) on a 35-bit input word and returns one 14-bit result.
- A LANES parameter trades area against latency: LANES shared table lanes are reused over ceil(7/LANES) passes.
- Valid/ready handshakes on both sides let it sit between the stream-cipher state registers and the feedback logic.

Parameters:
- LANES, 1, S-box lookups per cycle; legal range 1..7.
- NUM_SBOX, 7, number of S-boxes evaluated; fixed by the cipher; taken from the package.

Ports:
- clk  input  1  clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  35  bits [5k+4:5k] feed sbox(k+1), k=0..6.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  14  bits [2k+1:2k] = sbox(k+1) result.
- busy  output  1  high in EVAL or DONE.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, idx=0, operand and result registers=0.
  - out_valid=0, busy=0, out_data=0, in_ready=0.
- First cycle after rst falls: in_ready=1.
- States:
  - IDLE -> EVAL on in_valid&in_ready. The transfer latches in_data into the operand register and sets idx=0.
  - EVAL, each cycle:
    - Lane j (j=0..LANES-1) looks up sbox(idx+j+1) on operand bits [5(idx+j)+4:5(idx+j)].
    - It writes result bits [2(idx+j)+1:2(idx+j)].
    - Lanes with idx+j>=7 are disabled and write nothing.
    - idx += LANES.
    - When idx+LANES>=7 (last pass), next state is DONE.
  - DONE: out_valid=1 and out_data=result. Both stay stable until out_ready=1.
    - On out_valid&out_ready, go to IDLE, or to EVAL if a new input is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready and is permitted.
- Simultaneous output and input handshake in DONE: the result is delivered, the new operand is latched, idx=0, and the next state is EVAL. No bubble state is inserted.
- Latency: accept-edge to out_valid = P cycles, where P=ceil(7/LANES).
  - LANES=1: P=7. LANES=4: P=2. LANES=7: P=1.
- Throughput: one result per P+1 cycles when the consumer is always ready.
- in_data is ignored outside the accepting cycle. Operand changes after acceptance have no effect.
- Backpressure: while DONE with out_ready=0, in_ready=0 and no state changes. Hold time is unbounded.
- The result register is not cleared between transactions. Every bit is overwritten before DONE.
- Reset asserted mid-EVAL or mid-DONE aborts the transaction. No partial result ever appears on out_valid.
- idx width is 3 bits. idx never wraps because the last-pass check precedes overflow.
- busy=1 exactly when state is EVAL or DONE.

Decomposition:
- Package csa_sbox_pkg holds:
  - NUM_SBOX=7, SBOX_IN_W=5, SBOX_OUT_W=2.
  - The 7x32 2-bit table constants for sbox1..sbox7 (standard CSA stream-cipher tables).
  - The FSM state encoding (IDLE, EVAL, DONE).
  - A lookup function sbox_f(sel,in) for benches.
- Sub-module csa_sbox_lut: combinational, sel[2:0] + in[4:0] -> out[1:0].
  - Instantiated LANES times.
  - sel>=7 returns 0.

Test Plan:
- sbox3 check, LANES=1: in_data group2=5'h05, all other groups 0, accepted at cycle t. Required: out_valid rises at t+7, out_data[5:4]=2'h3, other fields match sbox_f(k,0).
- Table sweep, LANES=7: feed all 32 values into every group, out_ready=1 throughout. Required: each out_data matches sbox_f, including sbox3: 5'h00->2, 5'h1f->1, 5'h14->3, 5'h01->0. One result every 2 cycles.
- Backpressure, LANES=4: hold out_ready=0 for 10 cycles after out_valid. Required: out_data stable, in_ready=0, busy=1. Release out_ready with in_valid=1: result delivered and new input accepted in the same cycle, state EVAL, next out_valid 2 cycles later.
- Reset mid-EVAL, LANES=1: assert rst at pass 3 asynchronously (between edges). Required: out_valid=0 and busy=0 immediately, in_ready=1 after release, next transaction correct.
- Operand isolation: change in_data every cycle during EVAL. Required: result reflects only the value latched at acceptance.
- LANES=3 partial lanes: P=3 passes, lanes disabled in pass 3. Required: out_valid at t+3, all 14 bits correct.

Source files
------------

// File: rtl/csa_sbox_pkg.sv
// Shared constants, FSM encoding and the seven CSA stream-cipher S-box tables.
// Tables are indexed [sbox][5-bit input] and return the 2-bit S-box output.
package csa_sbox_pkg;

   localparam int NUM_SBOX   = 7;
   localparam int SBOX_IN_W  = 5;
   localparam int SBOX_OUT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] SBOX_TAB [NUM_SBOX][32] = '{
      '{2'd2,2'd0,2'd1,2'd1,2'd2,2'd3,2'd3,2'd0, 2'd3,2'd2,2'd2,2'd0,2'd1,2'd1,2'd0,2'd3,
        2'd0,2'd3,2'd3,2'd0,2'd2,2'd2,2'd1,2'd1, 2'd2,2'd2,2'd0,2'd3,2'd1,2'd1,2'd3,2'd0},
      '{2'd3,2'd1,2'd0,2'd2,2'd2,2'd3,2'd3,2'd0, 2'd1,2'd3,2'd2,2'd1,2'd0,2'd0,2'd1,2'd2,
        2'd3,2'd1,2'd0,2'd3,2'd3,2'd2,2'd0,2'd2, 2'd0,2'd0,2'd1,2'd2,2'd2,2'd1,2'd3,2'd1},
      '{2'd2,2'd0,2'd1,2'd2,2'd2,2'd3,2'd3,2'd1, 2'd1,2'd1,2'd0,2'd3,2'd3,2'd0,2'd2,2'd0,
        2'd1,2'd3,2'd0,2'd1,2'd3,2'd0,2'd2,2'd2, 2'd2,2'd0,2'd1,2'd2,2'd0,2'd3,2'd3,2'd1},
      '{2'd3,2'd1,2'd2,2'd3,2'd0,2'd2,2'd1,2'd2, 2'd1,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd3,
        2'd1,2'd0,2'd3,2'd1,2'd2,2'd3,2'd0,2'd3, 2'd0,2'd3,2'd2,2'd0,2'd1,2'd2,2'd2,2'd1},
      '{2'd2,2'd0,2'd0,2'd1,2'd3,2'd2,2'd3,2'd2, 2'd0,2'd1,2'd3,2'd3,2'd1,2'd0,2'd2,2'd1,
        2'd2,2'd3,2'd2,2'd0,2'd0,2'd3,2'd1,2'd1, 2'd1,2'd0,2'd3,2'd2,2'd3,2'd1,2'd0,2'd2},
      '{2'd0,2'd1,2'd2,2'd3,2'd1,2'd2,2'd2,2'd0, 2'd0,2'd1,2'd3,2'd0,2'd2,2'd3,2'd1,2'd3,
        2'd2,2'd3,2'd0,2'd2,2'd3,2'd0,2'd1,2'd1, 2'd2,2'd1,2'd1,2'd2,2'd0,2'd3,2'd3,2'd0},
      '{2'd0,2'd3,2'd2,2'd2,2'd3,2'd0,2'd0,2'd1, 2'd3,2'd0,2'd1,2'd3,2'd1,2'd2,2'd2,2'd1,
        2'd1,2'd0,2'd3,2'd3,2'd0,2'd1,2'd1,2'd2, 2'd2,2'd3,2'd1,2'd0,2'd2,2'd3,2'd0,2'd2}
   };

   // sel 0..6 picks sbox1..sbox7; anything above is a disabled lane.
   function automatic logic [SBOX_OUT_W-1:0] sbox_f(input logic [2:0]           sel,
                                                     input logic [SBOX_IN_W-1:0] din);
      if (sel >= 3'(NUM_SBOX)) return '0;
      return SBOX_TAB[sel][din];
   endfunction

endpackage

// File: rtl/csa_sbox_lut.sv
// One shared S-box lane: combinational table lookup selected by sel_i.
// Zero latency, no flow control; sel_i >= 7 yields 0.
module csa_sbox_lut
   import csa_sbox_pkg::*;
(
   input  logic [2:0]            sel_i,
   input  logic [SBOX_IN_W-1:0]  in_i,
   output logic [SBOX_OUT_W-1:0] out_o
);

   assign out_o = sbox_f(sel_i, in_i);

endmodule

// File: rtl/csa_sbox_seq.sv
// Sequential evaluation of all seven CSA S-boxes using LANES lookups per cycle.
// Latency ceil(7/LANES) cycles from accept to out_valid; result held until out_ready.
module csa_sbox_seq
   import csa_sbox_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [34:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] out_data,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [34:0] opnd_q, opnd_d;
   logic [13:0] result_q, result_d;

   logic [3:0]            lane_pos [LANES];
   logic [LANES-1:0]      lane_en;
   logic [2:0]            lane_sel [LANES];
   logic [SBOX_IN_W-1:0]  lane_in  [LANES];
   logic [SBOX_OUT_W-1:0] lane_out [LANES];
   logic                  last_pass;
   logic                  accept;

   // Lanes past sbox7 get sel=7, which both zeroes their operand and disables the table.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_pos[j] = {1'b0, idx_q} + 4'(j);
      assign lane_en[j]  = lane_pos[j] < 4'(NUM_SBOX);
      assign lane_sel[j] = lane_en[j] ? lane_pos[j][2:0] : 3'(NUM_SBOX);
      assign lane_in[j]  = SBOX_IN_W'(opnd_q >> (SBOX_IN_W * int'(lane_sel[j])));

      csa_sbox_lut u_lut (
         .sel_i (lane_sel[j]),
         .in_i  (lane_in[j]),
         .out_o (lane_out[j])
      );
   end

   assign last_pass = ({1'b0, idx_q} + 4'(LANES)) >= 4'(NUM_SBOX);
   assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = result_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EVAL;
               idx_d   = '0;
               opnd_d  = in_data;
            end
         end
         EVAL: begin
            for (int k = 0; k < NUM_SBOX; k++) begin
               for (int j = 0; j < LANES; j++) begin
                  if (lane_en[j] && (lane_sel[j] == 3'(k))) result_d[2*k +: 2] = lane_out[j];
               end
            end
            // idx is left alone on the last pass so it can never wrap.
            if (last_pass) state_d = DONE;
            else           idx_d   = idx_q + 3'(LANES);
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               if (accept) begin
                  state_d = EVAL;
                  idx_d   = '0;
                  opnd_d  = in_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         opnd_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
      end
   end

endmodule
